// File: rtl/uart_echo_ctrl.sv
// uart_echo_ctrl: loopback/echo controller between the board UART pins and the uart core.
// Latency: raw path rx->tx_raw SYNC_STAGES cycles; echo path rx_valid->wr_uart 3 cycles.
// Backpressure: tx_full is honoured before each pop (and before an inserted LF); a full echo FIFO drops bytes and sets sticky overflow.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   rx              raw asynchronous UART receive pin
//   mode            00 OFF, 01 RAW, 10 ECHO, 11 ECHO_UPPER
//   rx_data/rx_valid received byte strobe from the uart core
//   tx_full         uart core transmit FIFO full
//   tx_raw          raw loopback bit (idle high outside RAW)
//   wr_uart/w_data  one-cycle write strobe and byte to the uart core
//   curr_char/prev_char  last two received bytes for the display path
//   fifo_count      echo FIFO occupancy
//   overflow        sticky, a received byte was dropped
// Optional feature: define ECHO_CRLF_EN to follow every echoed 0x0D with an inserted 0x0A.
module uart_echo_ctrl #(
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic [1:0]                    mode,
  input  logic [DATA_BITS-1:0]          rx_data,
  input  logic                          rx_valid,
  input  logic                          tx_full,
  output logic                          tx_raw,
  output logic                          wr_uart,
  output logic [DATA_BITS-1:0]          w_data,
  output logic [DATA_BITS-1:0]          curr_char,
  output logic [DATA_BITS-1:0]          prev_char,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [DATA_BITS-1:0] LOWER_A   = DATA_BITS'('h61);
  localparam logic [DATA_BITS-1:0] LOWER_Z   = DATA_BITS'('h7A);
  localparam logic [DATA_BITS-1:0] CASE_DIFF = DATA_BITS'('h20);
  localparam logic [DATA_BITS-1:0] CHAR_CR   = DATA_BITS'('h0D);
`ifdef ECHO_CRLF_EN
  localparam logic [DATA_BITS-1:0] CHAR_LF   = DATA_BITS'('h0A);
`endif

`ifdef ECHO_CRLF_EN
  typedef enum logic [1:0] {IDLE, SEND, LF} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

  state_t                 state;
  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic                   raw_last;

  // Raw synchroniser. The first SYNC_STAGES-1 flops always run; tx_raw is
  // the final stage itself, forced high outside RAW so the total latency is
  // exactly SYNC_STAGES cycles with a registered output.
  generate
    if (SYNC_STAGES > 1) begin : g_sync
      logic [SYNC_STAGES-2:0] sync;
      always_ff @(posedge clk) begin
        if (rst) begin
          sync <= '1;
        end else begin
          sync[0] <= rx;
          for (int i = 1; i < SYNC_STAGES - 1; i++) sync[i] <= sync[i-1];
        end
      end
      assign raw_last = sync[SYNC_STAGES-2];
    end else begin : g_nosync
      assign raw_last = rx;
    end
  endgenerate

  logic                 echo_on;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic                 push_ok;
  logic [DATA_BITS-1:0] push_byte;

  assign echo_on    = mode[1];
  assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign push       = echo_on & rx_valid;
  // Pop decision uses the registered count, so a byte pushed this cycle
  // into an empty FIFO is only seen next cycle (no bypass).
  assign pop        = (state == IDLE) & ~fifo_empty & ~tx_full & echo_on;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push_ok    = push & (~fifo_full | pop);

  always_comb begin
    push_byte = rx_data;
    if (mode == 2'b11 && rx_data >= LOWER_A && rx_data <= LOWER_Z)
      push_byte = rx_data - CASE_DIFF;
  end

  // Storage carries no reset: a cleared count makes old contents unreachable.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= push_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_raw     <= 1'b1;
      wr_uart    <= 1'b0;
      w_data     <= '0;
      curr_char  <= '0;
      prev_char  <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      state      <= IDLE;
    end else begin
      tx_raw  <= (mode == 2'b01) ? raw_last : 1'b1;
      wr_uart <= 1'b0;

      if (rx_valid) begin
        prev_char <= curr_char;
        curr_char <= rx_data;
      end

      if (!echo_on) begin
        // Leaving the echo modes flushes the buffer and any pending send.
        fifo_count <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        state      <= IDLE;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
          w_data <= mem[rd_ptr];
        end
        fifo_count <= fifo_count + CW'(push_ok) - CW'(pop);
        if (push && fifo_full && !pop) overflow <= 1'b1;

        case (state)
          IDLE: if (pop) state <= SEND;
          SEND: begin
            wr_uart <= 1'b1;
`ifdef ECHO_CRLF_EN
            state   <= (w_data == CHAR_CR) ? LF : IDLE;
`else
            state   <= IDLE;
`endif
          end
`ifdef ECHO_CRLF_EN
          LF: begin
            // Skipping the cycle right after the CR strobe keeps writes
            // at least two cycles apart and lets tx_full reflect the CR.
            if (!tx_full && !wr_uart) begin
              w_data  <= CHAR_LF;
              wr_uart <= 1'b1;
              state   <= IDLE;
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// tb_uart_echo_ctrl: directed self-checking bench for uart_echo_ctrl (default parameters).
// Latency: checks raw 2-cycle delay, 3-cycle echo latency and CR/LF ordering.
// Backpressure: exercises tx_full stall, FIFO overflow and mid-echo reset.
module tb_uart_echo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_full = 1'b0;
  logic       tx_raw;
  logic       wr_uart;
  logic [7:0] w_data;
  logic [7:0] curr_char;
  logic [7:0] prev_char;
  logic [4:0] fifo_count;
  logic       overflow;

  uart_echo_ctrl dut (
    .clk(clk), .rst(rst), .rx(rx), .mode(mode),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_full(tx_full),
    .tx_raw(tx_raw), .wr_uart(wr_uart), .w_data(w_data),
    .curr_char(curr_char), .prev_char(prev_char),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] dat;
  } strobe_t;
  strobe_t q[$];

  always @(negedge clk) begin
    if (wr_uart === 1'b1) q.push_back('{cyc: cyc, dat: w_data});
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int b;
    b = 0;
    while (q.size() < n && b < budget) begin
      tick;
      b++;
    end
    repeat (4) tick;
  endtask

  function automatic logic [31:0] q_dat(input int i);
    logic [31:0] v;
    v = 'x;
    if (i < q.size()) v = {24'h0, q[i].dat};
    return v;
  endfunction

  function automatic logic [31:0] q_cyc(input int i);
    logic [31:0] v;
    v = 'x;
    if (i < q.size()) v = q[i].cyc;
    return v;
  endfunction

  initial begin
    int         t0;
    int         t_drop;
    logic       r_prev;
    logic [7:0] up_in  [4];
    logic [7:0] up_exp [4];

    up_in[0]  = 8'h61; up_in[1]  = 8'h7A; up_in[2]  = 8'h5B; up_in[3]  = 8'h31;
    up_exp[0] = 8'h41; up_exp[1] = 8'h5A; up_exp[2] = 8'h5B; up_exp[3] = 8'h31;

    // Power-on reset.
    repeat (3) tick;
    rst = 1'b0;
    chk("rst_tx_raw", tx_raw, 1);
    chk("rst_wr_uart", wr_uart, 0);
    chk("rst_w_data", w_data, 0);
    chk("rst_curr", curr_char, 0);
    chk("rst_prev", prev_char, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);

    // Raw mode: tx_raw follows rx two cycles later; 5-cycle low pulse.
    mode = 2'b01;
    rx   = 1'b1;
    repeat (3) tick;
    r_prev = 1'b1;
    for (int k = 0; k < 20; k++) begin
      rx = (k >= 2 && k < 7) ? 1'b0 : 1'b1;
      tick;
      chk("raw_mirror", tx_raw, r_prev);
      r_prev = rx;
    end
    // OFF mode keeps tx_raw idle high even with rx low.
    mode = 2'b00;
    rx   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("raw_off_idle", tx_raw, 1);
    end
    rx = 1'b1;

    // Echo: two bytes, first strobe 3 cycles after the first rx_valid.
    mode = 2'b10;
    tick;
    q.delete();
    rx_data = 8'h41; rx_valid = 1'b1; t0 = cyc;
    tick;
    rx_data = 8'h62;
    tick;
    rx_valid = 1'b0;
    wait_strobes(2, 20);
    chk("echo_n", q.size(), 2);
    chk("echo_d0", q_dat(0), 8'h41);
    chk("echo_d1", q_dat(1), 8'h62);
    chk("echo_lat", q_cyc(0) - t0, 3);
    chk("echo_curr", curr_char, 8'h62);
    chk("echo_prev", prev_char, 8'h41);
    chk("echo_count", fifo_count, 0);

    // Echo upper: only a..z are converted.
    mode = 2'b11;
    tick;
    q.delete();
    for (int i = 0; i < 4; i++) begin
      rx_data = up_in[i]; rx_valid = 1'b1;
      tick;
    end
    rx_valid = 1'b0;
    wait_strobes(4, 30);
    chk("upper_n", q.size(), 4);
    for (int i = 0; i < 4; i++) chk("upper_d", q_dat(i), up_exp[i]);

    // Overflow: 17 bytes into a stalled 16-entry FIFO.
    mode = 2'b10;
    tx_full = 1'b1;
    tick;
    q.delete();
    for (int i = 0; i < 17; i++) begin
      rx_data = 8'h80 + 8'(i); rx_valid = 1'b1;
      tick;
    end
    rx_valid = 1'b0;
    tick;
    chk("ovf_count", fifo_count, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_stalled", q.size(), 0);
    tx_full = 1'b0;
    wait_strobes(16, 100);
    chk("ovf_n", q.size(), 16);
    for (int i = 0; i < 16; i++) chk("ovf_d", q_dat(i), 8'h80 + 8'(i));
    chk("ovf_drain_count", fifo_count, 0);
    chk("ovf_sticky", overflow, 1);

    // Mid-echo reset with 5 bytes queued.
    tx_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rx_data = 8'h11 + 8'(i); rx_valid = 1'b1;
      tick;
    end
    rx_valid = 1'b0;
    tick;
    chk("mid_count5", fifo_count, 5);
    tx_full = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    chk("mid_count", fifo_count, 0);
    chk("mid_wr_uart", wr_uart, 0);
    chk("mid_tx_raw", tx_raw, 1);
    chk("mid_overflow", overflow, 0);
    chk("mid_curr", curr_char, 0);
    chk("mid_prev", prev_char, 0);
    chk("mid_w_data", w_data, 0);
    q.delete();
    repeat (10) tick;
    chk("mid_no_strobe", q.size(), 0);

    // CR echo with tx_full raised in the cycle after the CR strobe.
    q.delete();
    rx_data = 8'h0D; rx_valid = 1'b1; t0 = cyc;
    tick;
    rx_valid = 1'b0;
    tick;
    tick;
    chk("cr_strobe", wr_uart, 1);
    chk("cr_data", w_data, 8'h0D);
    tick;
    tx_full = 1'b1;
    chk("cr_strobe_end", wr_uart, 0);
    tick;
    tx_full = 1'b0;
    t_drop = cyc;
    wait_strobes(2, 20);
    chk("cr_d0", q_dat(0), 8'h0D);
`ifdef ECHO_CRLF_EN
    chk("crlf_n", q.size(), 2);
    chk("crlf_d1", q_dat(1), 8'h0A);
    chk("crlf_after_full", (q.size() > 1 && q[1].cyc > t_drop) ? 1 : 0, 1);
`else
    chk("cr_only_n", q.size(), 1);
`endif
    chk("cr_count", fifo_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
